// File: rtl/inflate_adler32_chk.sv
// Adler-32 checker on the inflate output stream: forwards bytes through a
// 2-entry skid buffer, sums accepted bytes, and compares against the zlib trailer.
module inflate_adler32_chk #(
    parameter logic [31:0] ADLER_INIT = 32'h0000_0001,
    parameter int unsigned MOD        = 65521
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic        finish,
    output logic [7:0]  out_data,
    output logic        out_vld,
    input  logic        out_rdy,
    input  logic [31:0] exp_adler,
    input  logic        exp_vld,
    output logic [31:0] adler,
    output logic [31:0] byte_cnt,
    output logic        chk_done,
    output logic        chk_ok,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [16:0] MOD17 = 17'(MOD);

    // Handshake: a byte moves on a port only in a cycle where both vld and rdy
    // are high at the rising clock edge; vld never waits on rdy.
    state_t      state_q, state_d;
    logic [7:0]  skid_mem [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        in_rdy_q;
    logic        acc, pop;
    logic [15:0] s1_q, s2_q, s1_d, s2_d;
    logic [16:0] t1, t2, t1_red, t2_red;
    logic [31:0] byte_cnt_q;
    logic [31:0] exp_reg_q;
    logic        exp_seen_q;
    logic        chk_done_q, chk_ok_q;
    logic        enter_done;

    // start blocks acceptance combinationally so an aborting cycle takes no byte.
    assign in_rdy   = in_rdy_q & ~start;
    assign acc      = in_vld & in_rdy;
    assign out_vld  = (count_q != 2'd0);
    assign out_data = skid_mem[rd_ptr_q];
    assign pop      = out_vld & out_rdy;

    assign adler     = {s2_q, s1_q};
    assign byte_cnt  = byte_cnt_q;
    assign chk_done  = chk_done_q;
    assign chk_ok    = chk_ok_q;
    assign state_dbg = state_q;

    always_comb begin
        count_d = count_q;
        case ({acc, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (start) begin
            count_d = 2'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (finish) state_d = S_FLUSH;
            S_FLUSH: begin
                if ((count_q == 2'd0) && exp_seen_q) begin
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d    = S_RUN;
            enter_done = 1'b0;
        end
    end

    // Both partial sums stay below MOD, so one conditional subtract suffices.
    always_comb begin
        t1     = {1'b0, s1_q} + {9'b0, in_data};
        t1_red = t1 - MOD17;
        s1_d   = (t1 >= MOD17) ? t1_red[15:0] : t1[15:0];
        t2     = {1'b0, s2_q} + {1'b0, s1_d};
        t2_red = t2 - MOD17;
        s2_d   = (t2 >= MOD17) ? t2_red[15:0] : t2[15:0];
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            skid_mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_rdy_q   <= 1'b0;
            s1_q       <= ADLER_INIT[15:0];
            s2_q       <= ADLER_INIT[31:16];
            byte_cnt_q <= 32'd0;
            exp_reg_q  <= 32'd0;
            exp_seen_q <= 1'b0;
            chk_done_q <= 1'b0;
            chk_ok_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            in_rdy_q <= (state_d == S_RUN) && (count_d < 2'd2);
            if (start) begin
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                s1_q       <= ADLER_INIT[15:0];
                s2_q       <= ADLER_INIT[31:16];
                byte_cnt_q <= 32'd0;
                exp_seen_q <= 1'b0;
                chk_done_q <= 1'b0;
                chk_ok_q   <= 1'b0;
            end else begin
                if (acc) begin
                    wr_ptr_q   <= ~wr_ptr_q;
                    s1_q       <= s1_d;
                    s2_q       <= s2_d;
                    byte_cnt_q <= byte_cnt_q + 32'd1;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                // First trailer pulse after start wins; later ones are ignored.
                if (exp_vld && !exp_seen_q && (state_q != S_IDLE)) begin
                    exp_reg_q  <= exp_adler;
                    exp_seen_q <= 1'b1;
                end
                if (enter_done) begin
                    chk_done_q <= 1'b1;
                    chk_ok_q   <= ({s2_q, s1_q} == exp_reg_q);
                end
            end
        end
    end

endmodule

// File: doc/inflate_adler32_chk.md
Name: inflate_adler32_chk

Overview:
- Sits directly downstream of the inflate core on its decoded-byte stream.
- Forwards every decoded byte through a 2-entry skid buffer and computes a running Adler-32 over the bytes it accepts.
- When the core signals end of decode, compares the running sum against the expected zlib trailer value supplied by the stream front end.
- Reports done/ok status to the top level and to the harness.

Parameters:
ADLER_INIT  32'h0000_0001  value loaded into {s2,s1} on start
MOD         65521          Adler modulus; fixed value, exposed for bench visibility only

Ports:
clk        input   1   clock
rst        input   1   asynchronous reset, active-high
start      input   1   one-cycle pulse; re-initialises the block for a new stream
in_data    input   8   decoded byte from inflate data_out
in_vld     input   1   in_data valid
in_rdy     output  1   block accepts in_data this cycle
finish     input   1   inflate decode_finish; level or pulse, sampled in RUN only
out_data   output  8   forwarded byte
out_vld    output  1   out_data valid
out_rdy    input   1   downstream sink ready
exp_adler  input   32  expected Adler-32 from zlib trailer, big-endian already assembled
exp_vld    input   1   one-cycle pulse capturing exp_adler
adler      output  32  current running checksum {s2,s1}
byte_cnt   output  32  bytes accepted since start, wraps at 2^32
chk_done   output  1   check complete, level, held until start
chk_ok     output  1   valid when chk_done; 1 = match

Behaviour:
- Reset (rst=1, async) clears the following:
  - State goes to IDLE and the skid buffer empties.
  - Outputs: out_vld=0, in_rdy=0, adler=ADLER_INIT, byte_cnt=0, chk_done=0, chk_ok=0.
  - The exp_adler capture register and its exp_seen flag clear.
- Accept condition: acc = in_vld & in_rdy.
  - in_rdy = (state==RUN) & (skid entries < 2). in_rdy is registered from occupancy.
- Skid buffer (2 entries, FIFO order, no byte dropped or duplicated):
  - Zero-bubble throughput: 1 byte/cycle when out_rdy is held high.
  - Latency from acc to out_vld is 1 cycle.
  - out_data/out_vld are driven from the head entry only. out_data is stable while out_vld & ~out_rdy.
- Checksum update on each acc, from pre-update s1/s2 (16b each):
  - t1 = s1 + in_data (17b); s1' = (t1 >= MOD) ? t1 - MOD : t1.
  - t2 = s2 + s1' (17b); s2' = (t2 >= MOD) ? t2 - MOD : t2.
  - adler = {s2', s1'} visible the cycle after acc.
  - byte_cnt increments on acc.
- State machine:
  - IDLE: in_rdy=0. start -> RUN, loading ADLER_INIT, clearing byte_cnt, exp_seen, chk_done and chk_ok.
  - RUN: if finish=1, go to FLUSH. A byte accepted in the same cycle as finish is included in the sum.
  - FLUSH: in_rdy=0; input bytes are not accepted. When the skid is empty and exp_seen=1, go to DONE.
  - DONE: chk_done=1 and chk_ok=(adler==exp_reg), both registered on entry. Stays in DONE until start.
- exp_vld handling:
  - Captured in any state except IDLE. The first pulse wins; later pulses are ignored until the next start.
  - exp_vld may arrive before finish, after finish, or in the same cycle as finish.
- start in any non-IDLE state aborts the current stream:
  - The skid is flushed and its contents discarded; out_vld=0 on the next cycle.
  - Then the block behaves as start from IDLE.
- start and acc in the same cycle: start has priority and the byte is not accepted, because in_rdy is forced 0 when start=1.
- Empty stream (finish with no bytes): the result is compared against ADLER_INIT.
- finish is ignored in IDLE, FLUSH and DONE.

Test Plan:
1. start, bytes "abc" (0x61,0x62,0x63), finish, exp_adler=0x024D0127 -> adler=0x024D0127, byte_cnt=3, chk_done=1, chk_ok=1; out stream = 61,62,63.
2. "Wikipedia" with out_rdy toggling 1-0-0-1 and random in_vld gaps -> output bytes identical and in order, adler=0x11E60398, chk_ok=1; out_data stable during stalls.
3. Modulo wrap: 300 bytes of 0xFF, exp=0xB90F2AE4 -> s1=0x2AE4, s2=0xB90F, chk_ok=1. Also exp=0xB90F2AE5 -> chk_done=1, chk_ok=0.
4. Ordering corners:
   - finish with no data, exp_vld 5 cycles later with 0x00000001 -> DONE only after exp_vld, chk_ok=1.
   - exp_vld before start -> ignored, block stays in FLUSH.
5. Last byte accepted in the same cycle as finish, with out_rdy=0 for 4 cycles -> chk_done asserts only after both skid entries drain; the byte is counted in the sum.
6. Aborts:
   - Mid-stream start after 2 bytes -> byte_cnt=0, adler=0x00000001, out_vld=0 next cycle.
   - rst pulse mid-stream -> all outputs return to reset values asynchronously.
